// File: rtl/bit_serial_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer:
// FSM state encoding and the default operand width.
package bit_serial_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/FA_1_bit.sv
// Single-bit full-adder slice; purely combinational.
module FA_1_bit (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/bit_serial_add_seq.sv
// Bit-serial WIDTH-bit add/subtract driving one FA_1_bit slice LSB first.
// Define ZERO_FLAG_EN to add a registered, serially computed zero flag output.
module bit_serial_add_seq
    import bit_serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
`ifdef ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             overflow
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;

    logic               fa_sum, fa_cout;
    logic               accept, last;

    FA_1_bit u_fa (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .c_in  (carry_q),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    assign ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy   = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);
    assign accept = ready && start;
    assign last   = busy && (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
                    a_d     = a_in;
                    b_d     = sub ? ~b_in : b_in;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                result_d = {fa_sum, result_q[WIDTH-1:1]};
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last) begin
                    // carry_q here is the carry into the MSB.
                    c_out_d = fa_cout;
                    ovf_d   = fa_cout ^ carry_q;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            c_out_q  <= c_out_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result   = result_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

`ifdef ZERO_FLAG_EN
    logic any_q, any_d;
    logic zero_q, zero_d;

    always_comb begin
        any_d  = any_q;
        zero_d = zero_q;
        if (accept) begin
            any_d = 1'b0;
        end else if (busy) begin
            any_d = any_q | fa_sum;
            if (last) begin
                zero_d = ~(any_q | fa_sum);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            any_q  <= any_d;
            zero_q <= zero_d;
        end
    end

    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_bit_serial_add_seq.sv
// Randomized self-checking bench for bit_serial_add_seq with a cycle-phase
// reference model and hand-computed literal cases.
module tb_bit_serial_add_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         ready, busy, done, c_out, overflow;
    logic [W-1:0] result;
`ifdef ZERO_FLAG_EN
    logic         zero;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bit_serial_add_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a_in     (a_in),
        .b_in     (b_in),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .c_out    (c_out),
`ifdef ZERO_FLAG_EN
        .zero     (zero),
`endif
        .overflow (overflow)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: modular arithmetic plus the signed-overflow rule.
    task automatic calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [W-1:0] r, output logic c, output logic ov,
                        output logic z);
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
        r    = full[W-1:0];
        c    = full[W];
        ov   = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        z    = (r == '0);
    endtask

    // ph: 0 idle, 1..W shifting, W+1 done cycle.
    int           ph = 0;
    logic [W-1:0] m_res = '0, p_res = '0;
    logic         m_c = 1'b0, m_ov = 1'b0, m_z = 1'b0;
    logic         p_c = 1'b0, p_ov = 1'b0, p_z = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph = 0; m_res = '0; m_c = 1'b0; m_ov = 1'b0; m_z = 1'b0;
        end else if ((ph == 0 || ph == W + 1) && start) begin
            calc(a_in, b_in, sub, p_res, p_c, p_ov, p_z);
            ph = 1;
        end else if (ph >= 1 && ph < W) begin
            ph++;
        end else if (ph == W) begin
            ph = W + 1; m_res = p_res; m_c = p_c; m_ov = p_ov; m_z = p_z;
        end else begin
            ph = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("ready", ready, (ph == 0 || ph == W + 1));
            chk("busy", busy, (ph >= 1 && ph <= W));
            chk("done", done, (ph == W + 1));
            chk("c_out", c_out, m_c);
            chk("overflow", overflow, m_ov);
            if (ph == 0 || ph == W + 1) chk("result", result, m_res);
`ifdef ZERO_FLAG_EN
            chk("zero", zero, m_z);
`endif
        end
    end

    // Issues one op from a negedge; returns at the negedge where done is seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input bit b2b, input bit spam, output int lat);
        if (!b2b) @(negedge clk);
        a_in = a; b_in = b; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 3 * W) begin
            @(negedge clk);
            lat++;
            if (spam && !done) begin
                start = 1'b1; a_in = W'($urandom); b_in = W'($urandom); sub = 1'($urandom);
            end
        end
        start = 1'b0;
    endtask

    task automatic lit_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input bit b2b, input bit spam, input logic [W-1:0] er,
                          input logic ec, input logic eov, input logic ez);
        int lat;
        run_op(a, b, s, b2b, spam, lat);
        chk("lit_latency", lat, W + 1);
        chk("lit_result", result, er);
        chk("lit_c_out", c_out, ec);
        chk("lit_overflow", overflow, eov);
        chk("model_result", m_res, er);
        chk("model_c_out", m_c, ec);
        chk("model_overflow", m_ov, eov);
`ifdef ZERO_FLAG_EN
        chk("lit_zero", zero, ez);
`else
        if (ez) chk("model_zero", m_z, 1'b1);
`endif
    endtask

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_c_out", c_out, 0);
        chk("rst_overflow", overflow, 0);
        #1 rst = 1'b0;

        lit_op(8'h35, 8'h4A, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0);
        lit_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        lit_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        lit_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        lit_op(8'h10, 8'h20, 1'b1, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0);
        // Back-to-back from the DONE cycle, then start spam during SHIFT.
        lit_op(8'h20, 8'h10, 1'b1, 1'b1, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0);
        lit_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 8'h46, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            int unsigned r;
            r = $urandom_range(0, 3);
            run_op(W'($urandom), W'($urandom), 1'($urandom), r == 0, r == 1, lat);
            chk("rand_latency", lat, W + 1);
            if (r == 3) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // Asynchronous reset four cycles into SHIFT.
        @(negedge clk);
        a_in = 8'h55; b_in = 8'h33; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_result", result, 0);
        chk("arst_c_out", c_out, 0);
        chk("arst_overflow", overflow, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (W + 2) @(negedge clk);
        lit_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
